// File: rtl/mul_booth_unit.sv
// mul_booth_unit: signed 32x32 radix-2 Booth multiplier, one multiplier bit per cycle.
// Optional MUL_EARLY_ZERO_EN: a zero operand skips the Booth iterations.
module mul_booth_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] zhi,
  output logic [31:0] zlo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic [32:0] r_mc, r_acc, w_sum;
  logic [31:0] r_q, r_zhi, r_zlo;
  logic [5:0]  r_cnt;
  logic        r_qm1, w_zero;
`ifdef MUL_EARLY_ZERO_EN
  assign w_zero = (mcand == '0) || (mplier == '0);
`else
  assign w_zero = 1'b0;
`endif
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = (r_cnt == '0) ? DONE : RUN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign w_sum = ({r_q[0], r_qm1} == 2'b01) ? r_acc + r_mc :
                 ({r_q[0], r_qm1} == 2'b10) ? r_acc - r_mc : r_acc;
  // A zero operand loads an empty count and cleared q, so the finishing RUN cycle yields 0.
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_mc  <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
      r_zhi <= '0;
      r_zlo <= '0;
    end else if (r_state == IDLE && start) begin
      r_mc  <= {mcand[31], mcand};
      r_acc <= '0;
      r_q   <= w_zero ? '0 : mplier;
      r_qm1 <= 1'b0;
      r_cnt <= w_zero ? 6'd0 : 6'd32;
    end else if (r_state == RUN && r_cnt != '0) begin
      r_acc <= {w_sum[32], w_sum[32:1]};
      r_q   <= {w_sum[0], r_q[31:1]};
      r_qm1 <= r_q[0];
      r_cnt <= r_cnt - 6'd1;
    end else if (r_state == RUN) begin
      r_zhi <= r_acc[31:0];
      r_zlo <= r_q;
    end
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign zhi  = r_zhi;
  assign zlo  = r_zlo;
endmodule

// File: tb/tb_mul_booth_unit.sv
// tb_mul_booth_unit: random and directed checks of mul_booth_unit against a cycle-level product model.
module tb_mul_booth_unit;
`ifdef MUL_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic        clk = 1'b0, clr = 1'b0, start = 1'b0;
  logic [31:0] mcand = '0, mplier = '0;
  logic        busy, done;
  logic [31:0] zhi, zlo;
  int          errors = 0, checks = 0;
  int          m_k = -1, m_lat = 33;
  logic [63:0] m_prod = '0, m_z = '0;

  mul_booth_unit dut (
    .clk(clk), .clr(clr), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .zhi(zhi), .zlo(zlo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
    return (EARLY && (a == '0 || b == '0)) ? 1 : 33;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // m_k counts edges since the accepted start; the result appears when it reaches m_lat.
  always @(posedge clk or negedge clr)
    if (!clr) begin
      m_k = -1;
      m_z = '0;
    end else if (m_k < 0) begin
      if (start) begin
        m_k = 0;
        m_prod = prod(mcand, mplier);
        m_lat = lat_of(mcand, mplier);
      end
    end else if (m_k == m_lat) m_k = -1;
    else begin
      m_k++;
      if (m_k == m_lat) m_z = m_prod;
    end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_k >= 0));
    chk("done", 64'(done), 64'(m_k >= 0 && m_k == m_lat));
    chk("zhi", 64'(zhi), 64'(m_z[63:32]));
    chk("zlo", 64'(zlo), 64'(m_z[31:0]));
  end

  task automatic run_op(input logic [31:0] mc, input logic [31:0] mp, input logic [63:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; mcand = mc; mplier = mp;
    @(negedge clk);
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      mcand = $urandom; mplier = $urandom;
    end
    chk("latency", 64'(n), 64'(lat_of(mc, mp) + 1));
    chk("op_zhi", 64'(zhi), 64'(exp[63:32]));
    chk("op_zlo", 64'(zlo), 64'(exp[31:0]));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] a, b;
    #22 clr = 1'b1;
    run_op(32'd7, 32'd5, 64'h0000_0000_0000_0023);
    run_op(32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run_op(32'h0, 32'h1234_5678, 64'h0);
    // start while busy: second request at cycle 10 must be dropped
    @(negedge clk);
    start = 1'b1; mcand = 32'd3; mplier = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; mcand = 32'd2; mplier = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n = 11;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_start_lat", 64'(n), 64'd34);
    chk("busy_start_zlo", 64'(zlo), 64'h9);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_second_done", 64'(n), 64'd0);
    // reset mid-operation
    @(negedge clk);
    start = 1'b1; mcand = 32'h1234; mplier = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_zhi", 64'(zhi), 64'd0);
    chk("rst_zlo", 64'(zlo), 64'd0);
    @(negedge clk);
    #2 clr = 1'b1;
    run_op(32'h1234, 32'h10, 64'h0000_0000_0001_2340);
    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      run_op(a, b, prod(a, b));
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
